// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data-memory handshake FSM and registered write-back bundle.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses trap (exc_misalignW) instead of reaching memory.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        validE,
    input  logic [31:0] ALUOutE,
    input  logic [4:0]  rwE,
    input  logic [DATA_W-1:0] bE,
    input  logic        RegWriteE,
    input  logic        MemReadE,
    input  logic        MemWriteE,
    output logic        stallM,
    mem_stage_if.master dmem,
    output logic        validW,
    output logic        RegWriteW,
    output logic [4:0]  rwW,
    output logic [31:0] resultW
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        exc_misalignW
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_e;

    state_e state_q, state_d;

    logic              valid_m_q;
    logic [31:0]       alu_m_q;
    logic [4:0]        rw_m_q;
    logic [DATA_W-1:0] b_m_q;
    logic              regwrite_m_q;
    logic              memread_m_q;
    logic              memwrite_m_q;

    logic              valid_w_q;
    logic              regwrite_w_q;
    logic [4:0]        rw_w_q;
    logic [31:0]       result_w_q;

    logic              is_store_m;
    logic              req_e;
    logic              misalign_m;
    logic              stall;
    logic              req;
    logic              complete;
    logic              load_done;
    state_e            capture_state;

    // Both MemRead and MemWrite set is a load, so a store needs MemRead clear.
    assign is_store_m = memwrite_m_q & ~memread_m_q;

`ifdef MEM_MISALIGN_TRAP_EN
    logic exc_w_q;
    assign req_e      = validE & (MemReadE | MemWriteE) & (ALUOutE[1:0] == 2'b00);
    assign misalign_m = valid_m_q & (memread_m_q | memwrite_m_q) & (alu_m_q[1:0] != 2'b00);
`else
    assign req_e      = validE & (MemReadE | MemWriteE);
    assign misalign_m = 1'b0;
`endif

    assign capture_state = req_e ? S_REQ : S_IDLE;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        stall     = 1'b0;
        req       = 1'b0;
        complete  = 1'b0;
        load_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // A valid M here is a non-memory op or a trapped misaligned access.
                complete = valid_m_q;
                state_d  = capture_state;
            end
            S_REQ: begin
                req = 1'b1;
                if (is_store_m) begin
                    if (dmem.dmem_ready) begin
                        complete = 1'b1;
                        state_d  = capture_state;
                    end else begin
                        stall = 1'b1;
                    end
                end else begin
                    stall = 1'b1;
                    if (dmem.dmem_ready) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dmem.dmem_rvalid) begin
                    complete  = 1'b1;
                    load_done = 1'b1;
                    state_d   = capture_state;
                end else begin
                    stall = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_m_q    <= 1'b0;
            alu_m_q      <= '0;
            rw_m_q       <= '0;
            b_m_q        <= '0;
            regwrite_m_q <= 1'b0;
            memread_m_q  <= 1'b0;
            memwrite_m_q <= 1'b0;
        end else if (!stall) begin
            valid_m_q    <= validE;
            alu_m_q      <= ALUOutE;
            rw_m_q       <= rwE;
            b_m_q        <= bE;
            regwrite_m_q <= RegWriteE;
            memread_m_q  <= MemReadE;
            memwrite_m_q <= MemWriteE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_w_q    <= 1'b0;
            regwrite_w_q <= 1'b0;
            rw_w_q       <= '0;
            result_w_q   <= '0;
        end else if (complete) begin
            valid_w_q    <= 1'b1;
            regwrite_w_q <= regwrite_m_q & ~misalign_m;
            rw_w_q       <= rw_m_q;
            result_w_q   <= load_done ? dmem.dmem_rdata : alu_m_q;
        end else begin
            // Bubble: destination and result keep their last values.
            valid_w_q    <= 1'b0;
            regwrite_w_q <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_w_q <= 1'b0;
        end else begin
            exc_w_q <= complete & misalign_m;
        end
    end
    assign exc_misalignW = exc_w_q;
`endif

    assign stallM          = stall;
    assign dmem.dmem_req   = req;
    assign dmem.dmem_we    = req & is_store_m;
    assign dmem.dmem_addr  = {alu_m_q[ADDR_W-1:2], 2'b00};
    assign dmem.dmem_wdata = b_m_q;

    assign validW    = valid_w_q;
    assign RegWriteW = regwrite_w_q;
    assign rwW       = rw_w_q;
    assign resultW   = result_w_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected write-backs are queued at issue and popped as W fires.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        validE = 1'b0;
    logic [31:0] ALUOutE = '0;
    logic [4:0]  rwE = '0;
    logic [31:0] bE = '0;
    logic        RegWriteE = 1'b0;
    logic        MemReadE = 1'b0;
    logic        MemWriteE = 1'b0;
    logic        stallM;
    logic        validW;
    logic        RegWriteW;
    logic [4:0]  rwW;
    logic [31:0] resultW;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        exc_misalignW;
`endif

    mem_stage_if #(.ADDR_W(32), .DATA_W(32)) dmem_bus ();

    mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .validE    (validE),
        .ALUOutE   (ALUOutE),
        .rwE       (rwE),
        .bE        (bE),
        .RegWriteE (RegWriteE),
        .MemReadE  (MemReadE),
        .MemWriteE (MemWriteE),
        .stallM    (stallM),
        .dmem      (dmem_bus.master),
        .validW    (validW),
        .RegWriteW (RegWriteW),
        .rwW       (rwW),
        .resultW   (resultW)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .exc_misalignW (exc_misalignW)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rw;
        logic [31:0] res;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] a, input logic [4:0] rw,
                            input logic [31:0] b, input logic rwe, input logic mr, input logic mw);
        validE = v; ALUOutE = a; rwE = rw; bE = b; RegWriteE = rwe; MemReadE = mr; MemWriteE = mw;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({stallM, dmem_bus.dmem_req, dmem_bus.dmem_we, validW, RegWriteW} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl got stall=%b req=%b we=%b validW=%b regW=%b expected all 0",
                     stallM, dmem_bus.dmem_req, dmem_bus.dmem_we, validW, RegWriteW);
        end
        vectors++;
        if ({rwW, resultW, dmem_bus.dmem_addr, dmem_bus.dmem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_data got rw=%0d res=%h addr=%h wdata=%h expected 0",
                     rwW, resultW, dmem_bus.dmem_addr, dmem_bus.dmem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu;
        drive_ex(1'b1, 32'h10, 5'd5, 32'h0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back('{rw: 5'd5, res: 32'h10, we: 1'b1});
        vectors++;
        if (stallM !== 1'b0) begin miscompares++; $display("FAIL alu_stall0 got %b expected 0", stallM); end
        tick();
        drive_ex(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if ({validW, stallM} !== 2'b00) begin
            miscompares++;
            $display("FAIL alu_edge1 got validW=%b stall=%b expected 0 0", validW, stallM);
        end
        tick();
        vectors++;
        if (validW !== 1'b1) begin
            miscompares++;
            $display("FAIL alu_latency got validW=%b expected 1", validW);
        end else begin
            e = exp_q.pop_front();
            if ({rwW, resultW, RegWriteW} !== {e.rw, e.res, e.we}) begin
                miscompares++;
                $display("FAIL alu_wb got rw=%0d res=%h we=%b expected rw=%0d res=%h we=%b",
                         rwW, resultW, RegWriteW, e.rw, e.res, e.we);
            end
        end
        tick();
        vectors++;
        if (validW !== 1'b0) begin miscompares++; $display("FAIL alu_bubble got validW=%b expected 0", validW); end
    endtask

    task automatic test_store;
        drive_ex(1'b1, 32'h100, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        exp_q.push_back('{rw: 5'd0, res: 32'h100, we: 1'b0});
        tick();
        drive_ex(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        dmem_bus.dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_wdata, stallM, validW}
                !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL store_hold[%0d] got req=%b we=%b addr=%h wdata=%h stall=%b validW=%b expected 1 1 100 deadbeef 1 0",
                         i, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_wdata, stallM, validW);
            end
            tick();
        end
        dmem_bus.dmem_ready = 1'b1;
        #1;
        vectors++;
        if ({dmem_bus.dmem_req, stallM} !== 2'b10) begin
            miscompares++;
            $display("FAIL store_accept got req=%b stall=%b expected 1 0", dmem_bus.dmem_req, stallM);
        end
        tick();
        dmem_bus.dmem_ready = 1'b0;
        vectors++;
        if (validW !== 1'b1) begin
            miscompares++;
            $display("FAIL store_latency got validW=%b expected 1", validW);
        end else begin
            e = exp_q.pop_front();
            if ({rwW, resultW, RegWriteW} !== {e.rw, e.res, e.we}) begin
                miscompares++;
                $display("FAIL store_wb got rw=%0d res=%h we=%b expected rw=%0d res=%h we=%b",
                         rwW, resultW, RegWriteW, e.rw, e.res, e.we);
            end
        end
        vectors++;
        if (dmem_bus.dmem_req !== 1'b0) begin miscompares++; $display("FAIL store_req_drop got %b expected 0", dmem_bus.dmem_req); end
        tick();
    endtask

    task automatic test_load;
        drive_ex(1'b1, 32'h200, 5'd7, 32'h0, 1'b1, 1'b1, 1'b0);
        exp_q.push_back('{rw: 5'd7, res: 32'h1234_5678, we: 1'b1});
        tick();
        drive_ex(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        dmem_bus.dmem_ready = 1'b1;
        #1;
        vectors++;
        if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, stallM} !== {1'b1, 1'b0, 32'h200, 1'b1}) begin
            miscompares++;
            $display("FAIL load_req got req=%b we=%b addr=%h stall=%b expected 1 0 200 1",
                     dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, stallM);
        end
        tick();
        dmem_bus.dmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({dmem_bus.dmem_req, stallM, validW} !== 3'b010) begin
                miscompares++;
                $display("FAIL load_wait[%0d] got req=%b stall=%b validW=%b expected 0 1 0",
                         i, dmem_bus.dmem_req, stallM, validW);
            end
            if (i == 0) tick();
        end
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = 32'h1234_5678;
        #1;
        vectors++;
        if (stallM !== 1'b0) begin miscompares++; $display("FAIL load_rvalid_stall got %b expected 0", stallM); end
        tick();
        dmem_bus.dmem_rvalid = 1'b0;
        dmem_bus.dmem_rdata  = 32'h0;
        vectors++;
        if (validW !== 1'b1) begin
            miscompares++;
            $display("FAIL load_latency got validW=%b expected 1", validW);
        end else begin
            e = exp_q.pop_front();
            if ({rwW, resultW, RegWriteW} !== {e.rw, e.res, e.we}) begin
                miscompares++;
                $display("FAIL load_wb got rw=%0d res=%h we=%b expected rw=%0d res=%h we=%b",
                         rwW, resultW, RegWriteW, e.rw, e.res, e.we);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back;
        drive_ex(1'b1, 32'h300, 5'd9, 32'h0, 1'b1, 1'b1, 1'b0);
        exp_q.push_back('{rw: 5'd9, res: 32'hCAFE_F00D, we: 1'b1});
        tick();
        drive_ex(1'b1, 32'hABC, 5'd10, 32'h0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back('{rw: 5'd10, res: 32'hABC, we: 1'b1});
        dmem_bus.dmem_ready = 1'b1;
        tick();
        dmem_bus.dmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({stallM, validW} !== 2'b10) begin
                miscompares++;
                $display("FAIL b2b_hold[%0d] got stall=%b validW=%b expected 1 0", i, stallM, validW);
            end
            if (i == 0) tick();
        end
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = 32'hCAFE_F00D;
        tick();
        dmem_bus.dmem_rvalid = 1'b0;
        drive_ex(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (validW !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_wb[%0d] got validW=%b expected 1", i, validW);
            end else begin
                e = exp_q.pop_front();
                if ({rwW, resultW, RegWriteW} !== {e.rw, e.res, e.we}) begin
                    miscompares++;
                    $display("FAIL b2b_wb[%0d] got rw=%0d res=%h we=%b expected rw=%0d res=%h we=%b",
                             i, rwW, resultW, RegWriteW, e.rw, e.res, e.we);
                end
            end
            tick();
        end
        vectors++;
        if (validW !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain got validW=%b pending=%0d expected 0 0", validW, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_in_wait;
        drive_ex(1'b1, 32'h400, 5'd11, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        drive_ex(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        dmem_bus.dmem_ready = 1'b1;
        tick();
        dmem_bus.dmem_ready = 1'b0;
        vectors++;
        if (stallM !== 1'b1) begin miscompares++; $display("FAIL rstwait_pre got stall=%b expected 1", stallM); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({dmem_bus.dmem_req, stallM, validW} !== 3'b000) begin
            miscompares++;
            $display("FAIL rstwait_async got req=%b stall=%b validW=%b expected 0 0 0",
                     dmem_bus.dmem_req, stallM, validW);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = 32'hBAD0_BAD0;
        #1;
        vectors++;
        if (stallM !== 1'b0) begin miscompares++; $display("FAIL rstwait_idle_stall got %b expected 0", stallM); end
        tick();
        dmem_bus.dmem_rvalid = 1'b0;
        vectors++;
        if ({validW, RegWriteW, dmem_bus.dmem_req} !== 3'b000) begin
            miscompares++;
            $display("FAIL rstwait_late_rvalid got validW=%b regW=%b req=%b expected 0 0 0",
                     validW, RegWriteW, dmem_bus.dmem_req);
        end
        tick();
    endtask

    task automatic test_misalign;
        drive_ex(1'b1, 32'h102, 5'd0, 32'h55, 1'b0, 1'b0, 1'b1);
        exp_q.push_back('{rw: 5'd0, res: 32'h102, we: 1'b0});
        tick();
        drive_ex(1'b0, 32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
`ifdef MEM_MISALIGN_TRAP_EN
        vectors++;
        if ({dmem_bus.dmem_req, stallM} !== 2'b00) begin
            miscompares++;
            $display("FAIL mis_noreq got req=%b stall=%b expected 0 0", dmem_bus.dmem_req, stallM);
        end
        tick();
        vectors++;
        if ({validW, exc_misalignW} !== 2'b11) begin
            miscompares++;
            $display("FAIL mis_trap got validW=%b exc=%b expected 1 1", validW, exc_misalignW);
        end
`else
        vectors++;
        if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr} !== {1'b1, 1'b1, 32'h100}) begin
            miscompares++;
            $display("FAIL mis_align got req=%b we=%b addr=%h expected 1 1 100",
                     dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr);
        end
        dmem_bus.dmem_ready = 1'b1;
        tick();
        dmem_bus.dmem_ready = 1'b0;
        vectors++;
        if (validW !== 1'b1) begin miscompares++; $display("FAIL mis_latency got validW=%b expected 1", validW); end
`endif
        if (validW === 1'b1) begin
            e = exp_q.pop_front();
            vectors++;
            if ({rwW, resultW, RegWriteW} !== {e.rw, e.res, e.we}) begin
                miscompares++;
                $display("FAIL mis_wb got rw=%0d res=%h we=%b expected rw=%0d res=%h we=%b",
                         rwW, resultW, RegWriteW, e.rw, e.res, e.we);
            end
        end
        tick();
        vectors++;
`ifdef MEM_MISALIGN_TRAP_EN
        if ({validW, exc_misalignW} !== 2'b00) begin
            miscompares++;
            $display("FAIL mis_after got validW=%b exc=%b expected 0 0", validW, exc_misalignW);
        end
`else
        if (validW !== 1'b0) begin miscompares++; $display("FAIL mis_after got validW=%b expected 0", validW); end
`endif
        exp_q.delete();
    endtask

    initial begin
        dmem_bus.dmem_ready  = 1'b0;
        dmem_bus.dmem_rvalid = 1'b0;
        dmem_bus.dmem_rdata  = '0;
        test_reset();
        test_alu();
        test_store();
        test_load();
        test_back_to_back();
        test_reset_in_wait();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t expected completion earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
